// File: rtl/debug_scan_sequencer.sv
// Purpose: walks the debug mux through the 21 SNN observables and streams each captured byte.
// Latency: start -> first m_valid in SETTLE_CYCLES+2 cycles; one beat per SETTLE_CYCLES+2 cycles unstalled.
// Backpressure: m_valid/m_data held until m_ready; next mux load waits for the handshake.
module debug_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int FCNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  output logic [7:0]        dbg_config_out,
  output logic              dbg_en,
  input  logic [7:0]        dbg_data_in,
  output logic [7:0]        m_data,
  output logic [4:0]        m_index,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, SEND} state_t;

  localparam logic [4:0]        LAST_IDX    = 5'd20;
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE    = {{(FCNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_d;
  logic [4:0]        idx, idx_d;
  logic [3:0]        cnt, cnt_d;
  logic              stop_pend, stop_pend_d;
  logic [7:0]        cfg_d, data_d;
  logic              en_d, valid_d, last_d, busy_d;
  logic [4:0]        index_d;
  logic [FCNT_W-1:0] fcnt_d;
  logic              beat_last;
  logic [4:0]        next_idx;

  // Mux select code for each beat: membranes 0..17, then layer 1/2/3 spike vectors.
  function automatic logic [7:0] code_of(input logic [4:0] i);
    logic [7:0] c;
    c = 8'h00;
    if (i == 5'd0)       c = 8'h20;
    else if (i <= 5'd17) c = {3'b000, i};
    else if (i == 5'd18) c = 8'h1E;
    else if (i == 5'd19) c = 8'h00;
    else if (i == 5'd20) c = 8'h1F;
    return c;
  endfunction

  // Next-state and next-output logic; every output is produced as a register input.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    cnt_d       = cnt;
    stop_pend_d = stop_pend;
    cfg_d       = dbg_config_out;
    en_d        = 1'b0;
    data_d      = m_data;
    index_d     = m_index;
    last_d      = m_last;
    valid_d     = m_valid;
    fcnt_d      = frame_count;
    beat_last   = (idx == LAST_IDX);
    next_idx    = beat_last ? 5'd0 : idx + 5'd1;

    if (state != IDLE && stop) stop_pend_d = 1'b1;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = 5'd0;
          en_d    = 1'b1;
          cfg_d   = code_of(5'd0);
        end
      end
      LOAD: begin
        state_d = SETTLE;
        cnt_d   = 4'd0;
      end
      SETTLE: begin
        cnt_d = cnt + 4'd1;
        if (cnt == SETTLE_LAST) begin
          data_d  = dbg_data_in;
          index_d = idx;
          last_d  = beat_last;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_valid && m_ready) begin
          valid_d = 1'b0;
          if (beat_last) fcnt_d = frame_count + FCNT_ONE;
          // A stop only ends the scan here, so an offered beat is never withdrawn.
          if (stop_pend || stop || (beat_last && !continuous)) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = LOAD;
            idx_d   = next_idx;
            en_d    = 1'b1;
            cfg_d   = code_of(next_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 5'd0;
      cnt            <= 4'd0;
      stop_pend      <= 1'b0;
      dbg_config_out <= 8'h00;
      dbg_en         <= 1'b0;
      m_data         <= 8'h00;
      m_index        <= 5'd0;
      m_last         <= 1'b0;
      m_valid        <= 1'b0;
      busy           <= 1'b0;
      frame_count    <= '0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      cnt            <= cnt_d;
      stop_pend      <= stop_pend_d;
      dbg_config_out <= cfg_d;
      dbg_en         <= en_d;
      m_data         <= data_d;
      m_index        <= index_d;
      m_last         <= last_d;
      m_valid        <= valid_d;
      busy           <= busy_d;
      frame_count    <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_debug_scan_sequencer.sv
// Purpose: scenario table plus hand sequences against a beat-level reference of the scan stream.
// Latency: checks first-valid timing and whole-frame cycle counts with an unstalled sink.
// Backpressure: random and forced m_ready stalls; held beats must stay frozen.
module tb_debug_scan_sequencer;

  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic          m_ready = 1'b0;
  logic [7:0]    dbg_config_out, dbg_data_in, m_data;
  logic          dbg_en, m_last, m_valid, busy;
  logic [4:0]    m_index;
  logic [FW-1:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int fc_model = 0;

  always #5 clk = ~clk;

  debug_scan_sequencer #(.SETTLE_CYCLES(2), .FCNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .dbg_config_out(dbg_config_out), .dbg_en(dbg_en), .dbg_data_in(dbg_data_in),
    .m_data(m_data), .m_index(m_index), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .frame_count(frame_count)
  );

  // Debug mux model: output is junk for one cycle after a config load, then a function of the code.
  logic [7:0] mux_cfg = 8'h00;
  logic       mux_wait = 1'b0;
  always @(posedge clk) begin
    mux_wait <= dbg_en;
    if (dbg_en) mux_cfg <= dbg_config_out;
  end
  assign dbg_data_in = mux_wait ? 8'hEE : (mux_cfg ^ 8'hA5);

  typedef struct {
    bit cont;
    int stop_at;     // load number during which stop is pulsed (-1: none)
    bit rand_rdy;
    int bp_beat;     // beat index held off for 10 cycles (-1: none)
    int poke_at;     // load number during which start is pulsed again (-1: none)
    int exp_beats;
    int exp_frames;
    int exp_cycles;  // busy cycles expected (-1: not checked)
  } vec_t;

  vec_t tbl[5];

  function automatic int ref_code(input int i);
    if (i == 0)  return 32;
    if (i <= 17) return i;
    if (i == 18) return 30;
    if (i == 19) return 0;
    return 31;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one scenario: start pulse, then per-cycle sink/stop driving and stream scoreboard.
  task automatic run_vec(input vec_t v);
    int loads = 0, hs = 0, bcyc = 0, first_valid = -1, hold = 0, bi;
    logic [7:0] pd = 8'h00;
    logic [4:0] pi = 5'd0;
    bit pstall = 1'b0;
    @(negedge clk);
    continuous = v.cont;
    start = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      if (!busy) break;
      bcyc++;
      if (dbg_en) begin
        chk("cfg_code", dbg_config_out, ref_code(loads % 21));
        chk("en_excl_valid", m_valid, 0);
        if (loads == v.stop_at) stop = 1'b1;
        if (loads == v.poke_at) start = 1'b1;
        loads++;
      end
      if (m_valid && first_valid < 0) first_valid = bcyc;
      if (pstall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_index", m_index, pi);
        chk("hold_en", dbg_en, 0);
      end
      if (m_valid && m_index == 5'(v.bp_beat) && hold < 10) begin
        m_ready = 1'b0;
        hold++;
      end else begin
        m_ready = v.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (m_valid && m_ready) begin
        bi = hs % 21;
        chk("beat_index", m_index, bi);
        chk("beat_data", m_data, ref_code(bi) ^ 8'hA5);
        chk("beat_last", m_last, (bi == 20) ? 1 : 0);
        hs++;
      end
      pstall = m_valid && !m_ready;
      pd = m_data;
      pi = m_index;
    end
    m_ready = 1'b0;
    fc_model = (fc_model + v.exp_frames) % (1 << FW);
    chk("end_busy", busy, 0);
    chk("beats", hs, v.exp_beats);
    chk("loads", loads, v.exp_beats);
    chk("frame_count", frame_count, fc_model);
    chk("first_valid", first_valid, 4);
    if (v.exp_cycles >= 0) chk("busy_cycles", bcyc, v.exp_cycles);
    if (v.bp_beat >= 0) chk("bp_hold", hold, 10);
  endtask

  initial begin
    vec_t wrap_v;
    int   w;
    tbl[0] = '{1'b0, -1, 1'b0, -1, -1, 21, 1, 84};
    tbl[1] = '{1'b0, -1, 1'b1,  5,  3, 21, 1, -1};
    tbl[2] = '{1'b1, 70, 1'b0, -1, -1, 71, 3, 284};
    tbl[3] = '{1'b1,  0, 1'b1, -1, -1,  1, 0, -1};
    tbl[4] = '{1'b1, 41, 1'b1, 20, 30, 42, 2, -1};
    wrap_v = '{1'b1, 105, 1'b0, -1, -1, 106, 5, -1};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_en", dbg_en, 0);
    chk("rst_cfg", dbg_config_out, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    chk("rst_last", m_last, 0);
    chk("rst_fc", frame_count, 0);
    rst_n = 1'b1;

    // start together with stop in IDLE is refused.
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("ss_busy", busy, 0);
    chk("ss_en", dbg_en, 0);
    chk("ss_valid", m_valid, 0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Reset while beat 12 sits in SEND.
    @(negedge clk);
    continuous = 1'b0;
    start = 1'b1;
    w = 0;
    while (w < 500 && !(m_valid && m_index == 5'd12)) begin
      @(negedge clk);
      start = 1'b0;
      m_ready = !(m_valid && m_index == 5'd12);
      w++;
    end
    chk("reach_beat12", m_index, 12);
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", dbg_en, 0);
    chk("mid_rst_cfg", dbg_config_out, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_index", m_index, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_fc", frame_count, 0);
    fc_model = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Five continuous frames from beat 0; 2-bit frame counter wraps to 1.
    run_vec(wrap_v);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
